// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: opcodes, field positions,
// decoded-control bundle and the ID/EX pipeline register layout.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
    logic        use_rs1;
    logic        use_rs2;
    logic [15:0] imm;
  } ctrl_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } id_ex_t;

  function automatic logic [15:0] sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational instruction decoder: instr_i -> control bundle,
// immediate and register-file read addresses (rs1_o, rs2_o).
module id_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [3:0]  rs1_o,
  output logic [3:0]  rs2_o
);

  logic [3:0] op;
  logic [3:0] rd;
  logic       is_r;
  ctrl_t      c;

  assign op   = instr_i[OP_HI:OP_LO];
  assign rd   = instr_i[RD_HI:RD_LO];
  assign is_r = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                           OP_XOR, OP_SHL, OP_SHR};

  always_comb begin
    c = '0;
    unique case (1'b1)
      (op == OP_NOP): ;
      is_r: begin
        c.reg_write = 1'b1;
        c.use_rs1   = 1'b1;
        c.use_rs2   = 1'b1;
      end
      (op == OP_ADDI): begin
        c.reg_write = 1'b1;
        c.use_rs1   = 1'b1;
        c.imm       = sext4(instr_i[3:0]);
      end
      (op == OP_LDI): begin
        c.reg_write = 1'b1;
        c.imm       = {8'h00, instr_i[7:0]};
      end
      (op == OP_LD): begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.use_rs1   = 1'b1;
        c.imm       = sext4(instr_i[3:0]);
      end
      (op == OP_ST): begin
        c.mem_write = 1'b1;
        c.use_rs1   = 1'b1;
        c.use_rs2   = 1'b1;
        c.imm       = sext4(instr_i[3:0]);
      end
      (op == OP_BEQ): begin
        c.use_rs1 = 1'b1;
        c.use_rs2 = 1'b1;
        c.imm     = sext4(rd);
      end
      (op == OP_JMP): begin
        c.imm = {{4{instr_i[11]}}, instr_i[11:0]};
      end
      default: c.illegal = 1'b1;
    endcase
    c.reg_write = c.reg_write & (rd != 4'd0);
  end

  assign ctrl_o = c;
  assign rs1_o  = instr_i[RS1_HI:RS1_LO];
  // Stores read their data register through the second port.
  assign rs2_o  = (op == OP_ST) ? rd : instr_i[RS2_HI:RS2_LO];

endmodule

// File: rtl/id_stage.sv
// Decode stage: fetch handshake in, register-file read addresses out,
// ID/EX register with pending-load scoreboard and branch flush.
module id_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_pc,
  input  logic        flush,
  output logic [3:0]  rf_rs1,
  output logic [3:0]  rf_rs2,
  input  logic [15:0] rf_rs1_data,
  input  logic [15:0] rf_rs2_data,
  input  logic        wb_load_done,
  input  logic [3:0]  wb_load_rd,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [3:0]  ex_op,
  output logic [3:0]  ex_rd,
  output logic [15:0] ex_a,
  output logic [15:0] ex_b,
  output logic [15:0] ex_imm,
  output logic [15:0] ex_pc,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_illegal
);

  ctrl_t       ctrl;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [15:0] pend_q, pend_d;
  logic [15:0] clr_mask, set_mask;
  logic [15:0] eff_pend, rd_mask;
  logic        hazard, take, xfer;
  logic        ex_valid_q, ex_valid_d;
  id_ex_t      id_ex_q, id_ex_d;

  id_decoder u_dec (
    .instr_i (if_instr),
    .ctrl_o  (ctrl),
    .rs1_o   (rs1),
    .rs2_o   (rs2)
  );

  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  assign xfer     = ex_valid_q & ex_ready;
  assign clr_mask = wb_load_done ? (16'h1 << wb_load_rd) : 16'h0;
  assign set_mask = (xfer & id_ex_q.mem_read & (id_ex_q.rd != 4'd0))
                  ? (16'h1 << id_ex_q.rd) : 16'h0;
  // Writeback clears apply this cycle; the RF bypass supplies the data.
  assign eff_pend = pend_q & ~clr_mask;
  assign pend_d   = eff_pend | set_mask;

  assign rd_mask = ((ctrl.use_rs1 ? (16'h1 << rs1) : 16'h0)
                 |  (ctrl.use_rs2 ? (16'h1 << rs2) : 16'h0))
                 & 16'hFFFE;
  assign hazard  = if_valid & (|(rd_mask & eff_pend));

  assign if_ready = ~hazard & (~ex_valid_q | ex_ready);
  assign take     = if_valid & if_ready & ~flush;

  always_comb begin
    ex_valid_d = ex_valid_q;
    id_ex_d    = id_ex_q;
    if (~ex_valid_q | ex_ready) ex_valid_d = take;
    if (take) begin
      id_ex_d = '{
        op:        if_instr[OP_HI:OP_LO],
        rd:        if_instr[RD_HI:RD_LO],
        a:         rf_rs1_data,
        b:         rf_rs2_data,
        imm:       ctrl.imm,
        pc:        if_pc,
        reg_write: ctrl.reg_write,
        mem_read:  ctrl.mem_read,
        mem_write: ctrl.mem_write,
        illegal:   ctrl.illegal
      };
    end
    if (flush) ex_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      id_ex_q    <= '0;
      pend_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      id_ex_q    <= id_ex_d;
      pend_q     <= pend_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_op        = id_ex_q.op;
  assign ex_rd        = id_ex_q.rd;
  assign ex_a         = id_ex_q.a;
  assign ex_b         = id_ex_q.b;
  assign ex_imm       = id_ex_q.imm;
  assign ex_pc        = id_ex_q.pc;
  assign ex_reg_write = id_ex_q.reg_write;
  assign ex_mem_read  = id_ex_q.mem_read;
  assign ex_mem_write = id_ex_q.mem_write;
  assign ex_illegal   = id_ex_q.illegal;

endmodule
